// File: rtl/stage_m_sized.sv
// Execute-to-memory pipeline stage shared by the RV and ARM datapaths.
// Holds the E/M register, owns the data memory (byte-enabled stores,
// extended loads), flags misaligned accesses and stretches loads over
// MEM_LAT cycles with a busy handshake to the hazard unit.
module stage_m_sized #(
  parameter int unsigned ADDR_BITS = 13,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        armE,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        MemWriteE,
  input  logic        MemReadE,
  input  logic [2:0]  SizeE,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        armM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ReadDataW,
  output logic        MemBusyM,
  output logic        MisalignM,
  output logic [31:0] WriteData,
  output logic [31:0] DataAddr,
  output logic        MemWrite,
  output logic [3:0]  ByteEn
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  // E/M register fields
  logic [31:0] alu_result_q, write_data_q, pc_plus4_q;
  logic [4:0]  rd_q;
  logic        arm_q, pc_src_q, reg_write_q, mem_write_q, mem_read_q;
  logic [1:0]  result_src_q;
  logic [2:0]  size_q;

  // load latency tracking
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_c;
  logic             started_q, started_d;

  // W-side captured load
  logic [31:0] raw_q;
  logic [1:0]  off_q;
  logic [2:0]  wsize_q;
  logic        wmis_q;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0] idx_c;
  logic        mis_c, busy_c, store_fire_c, rd_done_c;
  logic [3:0]  be_c;
  logic [31:0] lanes_c, rdata_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign idx_c = alu_result_q[ADDR_BITS+1:2];

  // E/M register: flush beats stall beats load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q <= '0; write_data_q <= '0; pc_plus4_q <= '0;
      rd_q <= '0; arm_q <= 1'b0; pc_src_q <= 1'b0; reg_write_q <= 1'b0;
      result_src_q <= '0; mem_write_q <= 1'b0; mem_read_q <= 1'b0;
      size_q <= '0;
    end else if (FlushM) begin
      alu_result_q <= '0; write_data_q <= '0; pc_plus4_q <= '0;
      rd_q <= '0; arm_q <= 1'b0; pc_src_q <= 1'b0; reg_write_q <= 1'b0;
      result_src_q <= '0; mem_write_q <= 1'b0; mem_read_q <= 1'b0;
      size_q <= '0;
    end else if (!StallM) begin
      alu_result_q <= ALUResultE; write_data_q <= WriteDataE;
      pc_plus4_q <= PCPlus4E; rd_q <= RdE; arm_q <= armE;
      pc_src_q <= PCSrcE; reg_write_q <= RegWriteE;
      result_src_q <= ResultSrcE; mem_write_q <= MemWriteE;
      mem_read_q <= MemReadE; size_q <= SizeE;
    end
  end

  // Misalignment, byte enables and replicated store lanes for the M access
  always_comb begin
    mis_c   = 1'b0;
    be_c    = 4'b0000;
    lanes_c = write_data_q;
    if (mem_read_q || mem_write_q) begin
      case (size_q[1:0])
        2'b00:   mis_c = 1'b0;
        2'b01:   mis_c = alu_result_q[0];
        default: mis_c = (alu_result_q[1:0] != 2'b00);
      endcase
    end
    case (size_q[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_result_q[1:0];
        lanes_c = {4{write_data_q[7:0]}};
      end
      2'b01: begin
        be_c    = alu_result_q[1] ? 4'b1100 : 4'b0011;
        lanes_c = {2{write_data_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        lanes_c = write_data_q;
      end
    endcase
    if (!(mem_write_q && !mis_c)) be_c = 4'b0000;
  end

  // Load latency: counter seeded with MEM_LAT-1 on the first M cycle of a load
  always_comb begin
    cnt_c = cnt_q;
    if (mem_read_q && !started_q && (cnt_q == '0)) cnt_c = LAT_M1;
    busy_c    = (cnt_c != '0);
    cnt_d     = busy_c ? cnt_c - CNT_W'(1) : '0;
    started_d = (FlushM || !StallM) ? 1'b0 : (started_q | mem_read_q);
    rd_done_c = mem_read_q && !busy_c && !StallM;
  end

  // Latency counter and "load already counted" flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      started_q <= started_d;
    end
  end

  assign store_fire_c = mem_write_q && !mis_c && !StallM;

  // Data memory write with per-lane enables; contents are not reset
  always_ff @(posedge clk) begin
    if (store_fire_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= lanes_c[8*b +: 8];
      end
    end
  end

  // W-side capture of the raw word and access shape when the read completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q   <= '0;
      off_q   <= '0;
      wsize_q <= '0;
      wmis_q  <= 1'b0;
    end else if (rd_done_c) begin
      raw_q   <= mem_q[idx_c];
      off_q   <= alu_result_q[1:0];
      wsize_q <= size_q;
      wmis_q  <= mis_c;
    end
  end

  // Lane select and sign/zero extension of the captured word
  always_comb begin
    byte_c = raw_q[{off_q, 3'b000} +: 8];
    half_c = off_q[1] ? raw_q[31:16] : raw_q[15:0];
    case (wsize_q[1:0])
      2'b00:   rdata_c = {{24{byte_c[7] & ~wsize_q[2]}}, byte_c};
      2'b01:   rdata_c = {{16{half_c[15] & ~wsize_q[2]}}, half_c};
      default: rdata_c = raw_q;
    endcase
    if (wmis_q) rdata_c = '0;
  end

  assign ALUResultM = alu_result_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RdM        = rd_q;
  assign PCSrcM     = pc_src_q;
  assign RegWriteM  = reg_write_q;
  assign armM       = arm_q;
  assign ResultSrcM = result_src_q;
  assign ReadDataW  = rdata_c;
  assign MemBusyM   = busy_c;
  assign MisalignM  = mis_c;
  assign WriteData  = lanes_c;
  assign DataAddr   = alu_result_q;
  assign MemWrite   = mem_write_q && !mis_c;
  assign ByteEn     = be_c;

endmodule

// File: doc/stage_m_sized.md
Name: stage_m_sized

Overview:
Parametrised successor to the execute-to-memory pipeline stage, shared by the RV and ARM datapaths.
- Registers E-stage results into M under stall/flush control.
- Owns the data memory, with byte/halfword/word stores (byte enables) and sign/zero-extended loads.
- Detects misaligned accesses.
- Supports a configurable multi-cycle memory read latency with a busy handshake to the hazard unit.

Parameters:
ADDR_BITS, 13, word-address bits; memory depth 2^ADDR_BITS 32-bit words, indexed by ALUResultM[ADDR_BITS+1:2]
MEM_LAT, 1, load read latency in cycles, legal range 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
StallM  in  1  hold E/M register
FlushM  in  1  load bubble into E/M register
ALUResultE  in  32  address / ALU result
WriteDataE  in  32  store data
PCPlus4E  in  32  RV only
RdE  in  5  destination register
armE  in  1  combi: instruction is ARM
PCSrcE  in  1  ARM only
RegWriteE  in  1  register write
ResultSrcE  in  2  result select; bit 1 RV only
MemWriteE  in  1  store
MemReadE  in  1  load
SizeE  in  3  access size, RV funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu
ALUResultM, PCPlus4M  out  32  registered copies
RdM  out  5  registered copy
PCSrcM, RegWriteM, armM  out  1  registered copies
ResultSrcM  out  2  registered copy
ReadDataW  out  32  extended load data
MemBusyM  out  1  multi-cycle load in progress; hazard unit must stall
MisalignM  out  1  current M access misaligned
WriteData, DataAddr  out  32  debug: aligned store data, ALUResultM
MemWrite  out  1  debug: effective store strobe
ByteEn  out  4  debug: store lane enables

Behaviour:
- Reset (rst=0, async): all E/M fields, ReadDataW, load counter and W-side offset/size regs go to 0.
  - MemBusyM=0, MisalignM=0.
  - Memory array contents are not reset.
- E/M register update priority: FlushM > StallM > load.
  - Flush: all fields 0, i.e. a bubble with no write, no load, no store.
  - Stall: hold all fields.
- Misalignment, combinational from M fields, only when MemReadM|MemWriteM:
  - halfword with ALUResultM[0]=1
  - word with ALUResultM[1:0]!=0
  - byte never misaligned
  - SizeE values 011/110/111 are treated as word.
- Store, at the clock edge ending the M cycle:
  - Active when MemWriteM & !MisalignM & !StallM.
  - ByteEn:
    - byte: 1<<addr[1:0]
    - half: addr[1]?1100:0011
    - word: 1111
    - 0 when not storing
  - Lane data: byte replicated ×4, half replicated ×2, word as-is; this is WriteData.
  - MemWrite = MemWriteM & !MisalignM.
- Load latency:
  - MEM_LAT=1: ReadDataW valid the cycle after M; MemBusyM always 0.
  - MEM_LAT=N>1: counter loads N-1 on the first M cycle of a load and decrements to 0.
    - MemBusyM=1 while the counter is nonzero, including that first M cycle.
    - The upstream hazard unit asserts StallM while MemBusyM=1.
    - ReadDataW is valid in the cycle after MemBusyM falls.
    - The counter does not restart while busy.
- W side:
  - Registers the raw word, addr[1:0] and size when the read completes; holds otherwise.
  - Extension (combinational from the registered values):
    - b/h sign-extend the selected lane.
    - bu/hu zero-extend.
    - w passes through.
  - A misaligned load returns 0.
- Address wrap: bits above ADDR_BITS+1 are ignored, so addresses alias modulo 4·2^ADDR_BITS bytes.
- Simultaneous store and load of the same word in consecutive cycles: the load returns the new data.
- Reset during a busy load aborts it: counter cleared, MemBusyM=0, no write performed.
- ARM accesses use the same SizeE encoding, decoded upstream (LDRB→100, STRB→000).

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0; release, no stray ByteEn.
- Byte stores and loads: sw 0x11223344 @0x100; sb 0x80 @0x101; lw @0x100 → 0x11228044; lb @0x101 → 0xFFFFFF80; lbu @0x101 → 0x00000080.
- Halfword and misalign: sh 0xBEEF @0x102 → ByteEn=1100; lh @0x102 → 0xFFFFBEEF; sh @0x103 → MisalignM=1, MemWrite=0, memory unchanged; lw @0x102 → MisalignM=1, ReadDataW=0.
- Stall/flush: assert StallM two cycles during a RegWriteE=1 stream → M fields held. FlushM with StallM both high → bubble (RegWriteM=0, ByteEn=0).
- MEM_LAT=3: lw issued → MemBusyM high 2 cycles; with the stall honoured, ReadDataW correct on the 3rd cycle after M entry. Assert rst mid-busy → MemBusyM drops immediately.
- Wrap, ADDR_BITS=4: sw 0xA5A5A5A5 @0x40; lw @0x00 → 0xA5A5A5A5.
